// File: rtl/dmem_request_unit_pkg.sv
// Shared definitions for the data-memory request unit.
// Contents:
//   MEM_WIDTH_1H_*  one-hot access-width codes (byte/half/word/double)
//   MEM_SIGNED      value of the load-sign flag for sign-extending loads
//   state_e         request-tracking FSM states
//   width_base_mask byte-enable mask for an access width, before shifting
package dmem_request_unit_pkg;

    localparam logic [3:0] MEM_WIDTH_1H_BYTE   = 4'b0001;
    localparam logic [3:0] MEM_WIDTH_1H_HALF   = 4'b0010;
    localparam logic [3:0] MEM_WIDTH_1H_WORD   = 4'b0100;
    localparam logic [3:0] MEM_WIDTH_1H_DOUBLE = 4'b1000;

    localparam logic MEM_SIGNED = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // A non-one-hot width yields an empty mask; such accesses are flagged
    // misaligned and never issued.
    function automatic logic [7:0] width_base_mask(input logic [3:0] width_1h);
        logic [7:0] mask;
        case (width_1h)
            MEM_WIDTH_1H_BYTE:   mask = 8'h01;
            MEM_WIDTH_1H_HALF:   mask = 8'h03;
            MEM_WIDTH_1H_WORD:   mask = 8'h0F;
            MEM_WIDTH_1H_DOUBLE: mask = 8'hFF;
            default:             mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_request_unit_store_aligner.sv
// Combinational lane placement for one data-memory access.
// Ports:
//   addr_lo_i     byte offset within the 8-byte bus word
//   width_1h_i    one-hot access width
//   wdata_i       store data, LSB-justified
//   be_o          byte enables for the 64-bit bus
//   wdata_o       store data shifted onto its byte lanes
//   misaligned_o  access crosses its natural boundary or width is invalid
module dmem_request_unit_store_aligner
    import dmem_request_unit_pkg::*;
(
    input  logic [2:0]  addr_lo_i,
    input  logic [3:0]  width_1h_i,
    input  logic [63:0] wdata_i,
    output logic [7:0]  be_o,
    output logic [63:0] wdata_o,
    output logic        misaligned_o
);

    always_comb begin
        be_o    = width_base_mask(width_1h_i) << addr_lo_i;
        wdata_o = wdata_i << {addr_lo_i, 3'b000};
        case (width_1h_i)
            MEM_WIDTH_1H_BYTE:   misaligned_o = 1'b0;
            MEM_WIDTH_1H_HALF:   misaligned_o = addr_lo_i[0];
            MEM_WIDTH_1H_WORD:   misaligned_o = |addr_lo_i[1:0];
            MEM_WIDTH_1H_DOUBLE: misaligned_o = |addr_lo_i;
            default:             misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_request_unit.sv
// Memory-stage initiator for the data-memory request/grant/response bus.
// Accepts one load or store at a time, issues it as an 8-byte-aligned
// request with byte enables, stalls the pipeline until the response returns
// and presents the raw 64-bit read data plus slicing controls to writeback.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   valid_i, squash_i         stage valid / kill
//   stall_i                   downstream stall, holds a completed result
//   mem_rd_en_i, mem_wr_en_i  load / store (both high acts as store)
//   addr_i, wdata_i           effective byte address, store data
//   mem_width_1h_i, mem_sign_i access width (one-hot), load sign
//   dmem_*_o, dmem_gnt_i      request channel
//   dmem_rvalid_i, dmem_rdata_i response channel
//   rdata_o, byte_addr_o, mem_width_1h_o, mem_sign_o  completed-op info
//   valid_o, misaligned_o, stall_o  completion, alignment fault, stall
module dmem_request_unit
    import dmem_request_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              squash_i,
    input  logic              stall_i,
    input  logic              mem_rd_en_i,
    input  logic              mem_wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [63:0]       wdata_i,
    input  logic [3:0]        mem_width_1h_i,
    input  logic              mem_sign_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [63:0]       dmem_wdata_o,
    output logic [7:0]        dmem_be_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [63:0]       dmem_rdata_i,
    output logic [63:0]       rdata_o,
    output logic [2:0]        byte_addr_o,
    output logic [3:0]        mem_width_1h_o,
    output logic              mem_sign_o,
    output logic              valid_o,
    output logic              misaligned_o,
    output logic              stall_o
);

    state_e             state_q;
    logic               req_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [63:0]        wdata_q;
    logic [7:0]         be_q;
    logic               squash_seen_q;
    // Attributes of the in-flight op, copied to the result on completion
    logic [2:0]         req_byte_q;
    logic [3:0]         req_width_q;
    logic               req_sign_q;
    // Completed-op result
    logic [63:0]        rdata_q;
    logic [2:0]         byte_addr_q;
    logic [3:0]         width_q;
    logic               sign_q;

    logic [7:0]         al_be;
    logic [63:0]        al_wdata;
    logic               al_misaligned;
    logic               op;
    logic               accepting;
    logic               accept;

    dmem_request_unit_store_aligner u_aligner (
        .addr_lo_i    (addr_i[2:0]),
        .width_1h_i   (mem_width_1h_i),
        .wdata_i      (wdata_i),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .misaligned_o (al_misaligned)
    );

    always_comb begin
        op           = valid_i & ~squash_i & (mem_rd_en_i | mem_wr_en_i);
        accepting    = (state_q == ST_IDLE) | ((state_q == ST_DONE) & ~stall_i);
        accept       = accepting & op & ~al_misaligned;
        misaligned_o = accepting & op & al_misaligned;
        stall_o      = accept | (state_q == ST_REQ) | (state_q == ST_WAIT_RSP)
                     | (state_q == ST_DRAIN);
        valid_o      = (state_q == ST_DONE) & ~squash_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            squash_seen_q <= 1'b0;
            req_byte_q    <= '0;
            req_width_q   <= '0;
            req_sign_q    <= 1'b0;
            rdata_q       <= '0;
            byte_addr_q   <= '0;
            width_q       <= '0;
            sign_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_q       <= ST_REQ;
                        req_q         <= 1'b1;
                        we_q          <= mem_wr_en_i;
                        addr_q        <= {addr_i[ADDR_W-1:3], 3'b000};
                        be_q          <= al_be;
                        wdata_q       <= mem_wr_en_i ? al_wdata : '0;
                        squash_seen_q <= 1'b0;
                        req_byte_q    <= addr_i[2:0];
                        req_width_q   <= mem_width_1h_i;
                        req_sign_q    <= mem_sign_i;
                    end else if (accepting) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= (squash_i | squash_seen_q) ? ST_DRAIN : ST_WAIT_RSP;
                    end else if (squash_i) begin
                        squash_seen_q <= 1'b1;
                    end
                end
                ST_WAIT_RSP: begin
                    // A squash arriving with the response drains in the same
                    // cycle; waiting in DRAIN would need a second rvalid.
                    if (dmem_rvalid_i) begin
                        if (squash_i) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q     <= ST_DONE;
                            rdata_q     <= dmem_rdata_i;
                            byte_addr_q <= req_byte_q;
                            width_q     <= req_width_q;
                            sign_q      <= req_sign_q;
                        end
                    end else if (squash_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (dmem_rvalid_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmem_req_o     = req_q;
    assign dmem_we_o      = we_q;
    assign dmem_addr_o    = addr_q;
    assign dmem_wdata_o   = wdata_q;
    assign dmem_be_o      = be_q;
    assign rdata_o        = rdata_q;
    assign byte_addr_o    = byte_addr_q;
    assign mem_width_1h_o = width_q;
    assign mem_sign_o     = sign_q;

endmodule

// File: doc/dmem_request_unit.md
Name: dmem_request_unit

Overview:
- Memory-stage initiator for the data-memory request/grant/response interface.
- Accepts a load or store from the execute pipeline register and checks alignment.
- For stores, shifts the data and builds the 8-bit byte enable for the 64-bit bus; aligns the address to 8 bytes.
- Tracks the single outstanding transaction, stalls the pipeline until the response returns, and hands the raw 64-bit read data plus slicing controls to writeback.

Parameters:
- ADDR_W, 64, byte-address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  instruction in stage is valid
- squash_i  in  1  kill instruction in stage
- stall_i  in  1  downstream stall; hold result
- mem_rd_en_i  in  1  load
- mem_wr_en_i  in  1  store
- addr_i  in  64  effective byte address
- wdata_i  in  64  store data, LSB-justified
- mem_width_1h_i  in  4  access width, one-hot
- mem_sign_i  in  1  load sign (pass-through)
- dmem_req_o  out  1  request
- dmem_we_o  out  1  write
- dmem_addr_o  out  64  8-byte-aligned address
- dmem_wdata_o  out  64  shifted store data
- dmem_be_o  out  8  byte enables
- dmem_gnt_i  in  1  grant
- dmem_rvalid_i  in  1  response valid
- dmem_rdata_i  in  64  response data
- rdata_o  out  64  captured read data
- byte_addr_o  out  3  addr[2:0] of completed op
- mem_width_1h_o  out  4  width of completed op
- mem_sign_o  out  1  sign of completed op
- valid_o  out  1  op completed this cycle
- misaligned_o  out  1  misaligned-access flag
- stall_o  out  1  pipeline stall request

Behaviour:
- Reset is synchronous and active-high; there is one clock.
- On reset: state IDLE.
  - dmem_req_o, dmem_we_o, valid_o, misaligned_o and stall_o are 0.
  - dmem_be_o = 0; dmem_addr_o, dmem_wdata_o and rdata_o = 0.
  - byte_addr_o = 0, mem_width_1h_o = 0, mem_sign_o = 0.
- Reset mid-transaction abandons the transaction. dmem_rvalid_i seen in IDLE is ignored.
- op = valid_i & ~squash_i & (mem_rd_en_i | mem_wr_en_i). Both enables high is illegal; it is treated as a store.
- Alignment rule:
  - Misaligned when HALF and addr[0] is set; WORD and addr[1:0] != 0; DOUBLE and addr[2:0] != 0.
  - A non-one-hot width is also misaligned.
- Byte-enable base masks: BYTE 0x01, HALF 0x03, WORD 0x0F, DOUBLE 0xFF.
  - dmem_be_o = base << addr[2:0] (8-bit result).
  - dmem_wdata_o = wdata_i << (8*addr[2:0]), truncated to 64 bits.
  - dmem_addr_o = {addr[63:3], 3'b000}.
  - For loads, dmem_be_o = base mask shifted the same way and dmem_wdata_o = 0.
- Accepting states are IDLE and DONE.
  - If op is aligned: register all request fields, go to REQ. stall_o = 1 in the accept cycle.
  - If op is misaligned: misaligned_o = 1 combinationally, no request, state unchanged, stall_o = 0.
- REQ:
  - dmem_req_o = 1 from registers.
  - All request outputs are held stable until dmem_gnt_i.
  - On gnt: go to WAIT_RSP, or to DRAIN if squash_i is seen in REQ or in the gnt cycle.
  - Requests are never retracted. A squashed store still writes memory. Upstream guarantees that stores reaching the stage are non-speculative.
  - stall_o = 1.
- WAIT_RSP:
  - dmem_req_o = 0; stall_o = 1.
  - squash_i moves the state to DRAIN.
  - dmem_rvalid_i captures dmem_rdata_i into rdata_o and moves to DONE.
  - rvalid is never earlier than the cycle after gnt. Stores also receive an rvalid.
- DRAIN:
  - stall_o = 1.
  - On rvalid: go to IDLE; data is discarded and valid_o stays 0.
- DONE:
  - valid_o = 1; rdata_o, byte_addr_o, mem_width_1h_o and mem_sign_o are stable; stall_o = 0.
  - If stall_i: stay in DONE and hold all outputs.
  - Else: accept a new op (DONE->REQ back-to-back) or go to IDLE.
  - squash_i in DONE clears valid_o combinationally.
- Back-to-back latency: accept -> REQ (1) -> gnt -> WAIT_RSP -> rvalid -> DONE. The minimum is 3 cycles from accept to valid_o.

Decomposition:
- Shared header Lucid64.vh holds:
  - MEM_WIDTH_1H_BYTE/HALF/WORD/DOUBLE (0001/0010/0100/1000).
  - MEM_SIGNED.
  - State encodings IDLE/REQ/WAIT_RSP/DRAIN/DONE.
- One combinational sub-module, store_aligner, takes addr[2:0], width and wdata and produces be, wdata and misaligned. The FSM stays in dmem_request_unit.

Test Plan:
- Store WORD, addr 0x1004, wdata 0xDEADBEEF, gnt on the first REQ cycle, rvalid 1 cycle later:
  - dmem_addr_o 0x1000, be 0xF0, wdata_o 0xDEADBEEF_00000000, we 1.
  - valid_o 3 cycles after accept.
- Load BYTE, addr 0x2007, gnt delayed 4 cycles, rdata 0x8800_0000_0000_0000:
  - req held stable for 4 cycles, be 0x80.
  - rdata_o 0x8800000000000000, byte_addr_o 7.
  - stall_o high until DONE.
- Load HALF at addr 0x3001 -> misaligned_o 1, dmem_req_o never asserts, stall_o 0, valid_o 0.
- Load with squash_i in WAIT_RSP:
  - DRAIN until rvalid, valid_o never asserts.
  - A following load is issued only after IDLE is reached.
- DONE with stall_i held 3 cycles, then a new DOUBLE load at 0x4000:
  - outputs frozen for 3 cycles.
  - DONE->REQ directly, be 0xFF.
- rst_i asserted in REQ:
  - next cycle all outputs are 0 and state is IDLE.
  - a stray rvalid afterwards produces no valid_o.
